vmx_result_requantizer: RTL and testbench



---
 rtl/vmx_pkg.sv | 36 +++
 rtl/vmx_requant_lane.sv | 51 +++++
 rtl/vmx_result_requantizer.sv | 124 ++++++++++++
 tb/tb_vmx_result_requantizer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vmx_pkg.sv
// vmx_pkg: lane-width constants, int16 saturation bounds and lane slice
// helpers shared by the VMX execute processor and the result requantizer.
package vmx_pkg;

  localparam int ACC_WIDTH   = 32;  // signed accumulator width per lane
  localparam int OUT_WIDTH   = 16;  // signed requantized width per lane
  localparam int SHIFT_WIDTH = 5;   // right-shift amount 0..31

  // Saturation bounds in the ACC_WIDTH+1 intermediate domain
  localparam logic signed [ACC_WIDTH:0] SAT_MAX = 33'sh0_0000_7FFF;
  localparam logic signed [ACC_WIDTH:0] SAT_MIN = 33'sh1_FFFF_8000;

  // LSB position of lane k in a packed accumulator word
  function automatic int acc_lane_lsb(input int k);
    return k * ACC_WIDTH;
  endfunction

  // LSB position of lane k in a packed result word
  function automatic int out_lane_lsb(input int k);
    return k * OUT_WIDTH;
  endfunction

  // Clamp a rounded/shifted value to the signed OUT_WIDTH range
  function automatic logic [OUT_WIDTH-1:0] sat_to_out(input logic signed [ACC_WIDTH:0] r);
    logic [OUT_WIDTH-1:0] res_v;
    if (r > SAT_MAX) begin
      res_v = 16'h7FFF;
    end else if (r < SAT_MIN) begin
      res_v = 16'h8000;
    end else begin
      res_v = r[OUT_WIDTH-1:0];
    end
    return res_v;
  endfunction

endpackage

// File: rtl/vmx_requant_lane.sv
// vmx_requant_lane: combinational requantization of one accumulator lane.
// Rounding arithmetic right shift in ACC_WIDTH+1 bits, int16 saturation and,
// when VMX_RELU_EN is defined, clamping of negative results to zero.
// Ports:
//   acc    in  ACC_WIDTH    signed accumulator
//   shift  in  SHIFT_WIDTH  right-shift amount
//   res    out OUT_WIDTH    saturated signed result
module vmx_requant_lane
  import vmx_pkg::*;
(
  input  logic [ACC_WIDTH-1:0]   acc,
  input  logic [SHIFT_WIDTH-1:0] shift,
  output logic [OUT_WIDTH-1:0]   res
);

  logic signed [ACC_WIDTH:0] acc_ext_s;
  logic signed [ACC_WIDTH:0] round_s;
  logic signed [ACC_WIDTH:0] sum_s;
  logic signed [ACC_WIDTH:0] shifted_s;
  logic [OUT_WIDTH-1:0]      sat_s;

  // Round-half-up shift; the extra MSB absorbs the rounding carry of 0x7FFFFFFF
  always_comb begin
    acc_ext_s = {acc[ACC_WIDTH-1], acc};
    if (shift != 5'd0) begin
      round_s = {{ACC_WIDTH{1'b0}}, 1'b1} << (shift - 5'd1);
    end else begin
      round_s = '0;
    end
    sum_s     = acc_ext_s + round_s;
    shifted_s = sum_s >>> shift;
    sat_s     = sat_to_out(shifted_s);
  end

`ifdef VMX_RELU_EN
  // Rectify: negative saturated lanes become zero
  always_comb begin
    if (sat_s[OUT_WIDTH-1]) begin
      res = '0;
    end else begin
      res = sat_s;
    end
  end
`else
  // Signed saturated value passes through unchanged
  always_comb begin
    res = sat_s;
  end
`endif

endmodule

// File: rtl/vmx_result_requantizer.sv
// vmx_result_requantizer: pops accumulator entries from the EAQ FIFO, applies
// a rounding right shift and int16 saturation per lane, and writes packed
// results to the result FIFO. Counts rows and completed tiles.
// Optional feature: define VMX_RELU_EN to clamp negative lanes to zero.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   halt             freeze all state, both FIFO enables low
//   QUANT_SHIFT      shift amount, sampled with each popped entry
//   EAQ_FIFO_*       first-word-fall-through source (DATA, EMPTY, RENA)
//   RES_FIFO_*       result sink (DATA, FULL, WENA)
//   TILE_DONE        pulse on the write that completes a tile
//   TILE_COUNT       completed tiles (wrapping)
//   BUSY             pipeline occupied or source not empty
module vmx_result_requantizer
  import vmx_pkg::*;
#(
  parameter int PE_SIZE = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          halt,
  input  logic [SHIFT_WIDTH-1:0]        QUANT_SHIFT,
  input  logic [PE_SIZE*ACC_WIDTH-1:0]  EAQ_FIFO_DATA,
  input  logic                          EAQ_FIFO_EMPTY,
  output logic                          EAQ_FIFO_RENA,
  output logic [PE_SIZE*OUT_WIDTH-1:0]  RES_FIFO_DATA,
  input  logic                          RES_FIFO_FULL,
  output logic                          RES_FIFO_WENA,
  output logic                          TILE_DONE,
  output logic [15:0]                   TILE_COUNT,
  output logic                          BUSY
);

  localparam int ROW_W = (PE_SIZE > 1) ? $clog2(PE_SIZE) : 1;
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(PE_SIZE - 1);

  logic [PE_SIZE*ACC_WIDTH-1:0] s1_data_r;
  logic [SHIFT_WIDTH-1:0]       s1_shift_r;
  logic                         s1_valid_r;
  logic [PE_SIZE*OUT_WIDTH-1:0] s2_data_r;
  logic                         s2_valid_r;
  logic [ROW_W-1:0]             row_r;
  logic [15:0]                  tile_count_r;

  logic [PE_SIZE*OUT_WIDTH-1:0] lane_res_s;
  logic                         wena_s;
  logic                         s2_load_s;
  logic                         rena_s;
  logic                         last_row_s;

  // Pipeline handshakes; rst masks the enables so nothing moves during reset
  always_comb begin
    wena_s     = !rst && !halt && s2_valid_r && !RES_FIFO_FULL;
    s2_load_s  = !halt && s1_valid_r && (!s2_valid_r || wena_s);
    rena_s     = !rst && !halt && !EAQ_FIFO_EMPTY && (!s1_valid_r || s2_load_s);
    last_row_s = (row_r == ROW_LAST);
  end

  assign EAQ_FIFO_RENA = rena_s;
  assign RES_FIFO_WENA = wena_s;
  assign RES_FIFO_DATA = s2_data_r;
  assign TILE_DONE     = wena_s && last_row_s;
  assign TILE_COUNT    = tile_count_r;
  assign BUSY          = s1_valid_r || s2_valid_r || !EAQ_FIFO_EMPTY;

  // S1: capture popped entry and its shift; empties when handed to S2
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_data_r  <= '0;
      s1_shift_r <= '0;
      s1_valid_r <= 1'b0;
    end else if (rena_s) begin
      s1_data_r  <= EAQ_FIFO_DATA;
      s1_shift_r <= QUANT_SHIFT;
      s1_valid_r <= 1'b1;
    end else if (s2_load_s) begin
      s1_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= s1_valid_r;
    end
  end

  // Per-lane round/shift/saturate between the S1 and S2 registers
  for (genvar k = 0; k < PE_SIZE; k++) begin : g_lane
    vmx_requant_lane u_lane (
      .acc   (s1_data_r[acc_lane_lsb(k) +: ACC_WIDTH]),
      .shift (s1_shift_r),
      .res   (lane_res_s[out_lane_lsb(k) +: OUT_WIDTH])
    );
  end

  // S2: packed result register; data holds after the write drains it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_data_r  <= '0;
      s2_valid_r <= 1'b0;
    end else if (s2_load_s) begin
      s2_data_r  <= lane_res_s;
      s2_valid_r <= 1'b1;
    end else if (wena_s) begin
      s2_valid_r <= 1'b0;
    end else begin
      s2_valid_r <= s2_valid_r;
    end
  end

  // Row and tile counters advance on each result write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_r        <= '0;
      tile_count_r <= 16'd0;
    end else if (wena_s) begin
      if (last_row_s) begin
        row_r        <= '0;
        tile_count_r <= tile_count_r + 16'd1;
      end else begin
        row_r        <= row_r + ROW_W'(1);
      end
    end else begin
      row_r <= row_r;
    end
  end

endmodule

// File: tb/tb_vmx_result_requantizer.sv
// tb_vmx_result_requantizer: directed self-checking bench with a FWFT source
// model and a write log for the result FIFO side.
module tb_vmx_result_requantizer;

  localparam int PE = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         halt = 1'b0;
  logic [4:0]   QUANT_SHIFT = 5'd0;
  logic [127:0] EAQ_FIFO_DATA = '0;
  logic         EAQ_FIFO_EMPTY = 1'b1;
  logic         EAQ_FIFO_RENA;
  logic [63:0]  RES_FIFO_DATA;
  logic         RES_FIFO_FULL = 1'b0;
  logic         RES_FIFO_WENA;
  logic         TILE_DONE;
  logic [15:0]  TILE_COUNT;
  logic         BUSY;

  vmx_result_requantizer #(.PE_SIZE(PE)) dut (
    .clk            (clk),
    .rst            (rst),
    .halt           (halt),
    .QUANT_SHIFT    (QUANT_SHIFT),
    .EAQ_FIFO_DATA  (EAQ_FIFO_DATA),
    .EAQ_FIFO_EMPTY (EAQ_FIFO_EMPTY),
    .EAQ_FIFO_RENA  (EAQ_FIFO_RENA),
    .RES_FIFO_DATA  (RES_FIFO_DATA),
    .RES_FIFO_FULL  (RES_FIFO_FULL),
    .RES_FIFO_WENA  (RES_FIFO_WENA),
    .TILE_DONE      (TILE_DONE),
    .TILE_COUNT     (TILE_COUNT),
    .BUSY           (BUSY)
  );

  always #5 clk = ~clk;

  logic [127:0] src_mem [0:31];
  int n_src = 0, head = 0, cyc = 0;
  int full_lo = 0, full_hi = -1, halt_lo = 0, halt_hi = -1;
  int n_tests = 0, n_fail = 0;
  int bp_rena = 0, full_wena = 0, halt_err = 0;
  logic [63:0] wr_q [$];
  int          wr_cyc_q [$];
  logic        td_q [$];
  int          pop_cyc_q [$];

  function automatic logic [127:0] pack4(input logic [31:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  // Expected value of a negative saturated lane for this build
  function automatic logic [15:0] neg_out(input logic [15:0] v);
`ifdef VMX_RELU_EN
    return 16'h0000;
`else
    return v;
`endif
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic drive_head();
    if (head < n_src) begin
      EAQ_FIFO_EMPTY = 1'b0;
      EAQ_FIFO_DATA  = src_mem[head];
    end else begin
      EAQ_FIFO_EMPTY = 1'b1;
      EAQ_FIFO_DATA  = '0;
    end
  endtask

  task automatic clear_logs();
    wr_q.delete(); wr_cyc_q.delete(); td_q.delete(); pop_cyc_q.delete();
    bp_rena = 0; full_wena = 0; halt_err = 0; cyc = 0;
  endtask

  // One clock: apply windows, sample at negedge, retire popped head after posedge
  task automatic tick();
    logic rena_v;
    RES_FIFO_FULL = (cyc + 1 >= full_lo) && (cyc + 1 <= full_hi);
    halt          = (cyc + 1 >= halt_lo) && (cyc + 1 <= halt_hi);
    @(negedge clk);
    cyc++;
    if (RES_FIFO_WENA) begin
      wr_q.push_back(RES_FIFO_DATA);
      wr_cyc_q.push_back(cyc);
      td_q.push_back(TILE_DONE);
    end
    if (EAQ_FIFO_RENA) pop_cyc_q.push_back(cyc);
    if (RES_FIFO_FULL && EAQ_FIFO_RENA) bp_rena++;
    if (RES_FIFO_FULL && RES_FIFO_WENA) full_wena++;
    if (halt && (EAQ_FIFO_RENA || RES_FIFO_WENA || TILE_DONE)) halt_err++;
    rena_v = EAQ_FIFO_RENA;
    @(posedge clk);
    #1;
    if (rena_v) head++;
    drive_head();
  endtask

  // Run until nwr writes are logged (bounded), then idle to expose duplicates
  task automatic run_until(input string tag, input int nwr, input int budget);
    int start;
    start = cyc;
    while (wr_q.size() < nwr && cyc - start < budget) tick();
    for (int i = 0; i < 3; i++) tick();
    check_eq({tag, "_wr_count"}, 64'(wr_q.size()), 64'(nwr));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    full_lo = 0; full_hi = -1; halt_lo = 0; halt_hi = -1;
    halt = 1'b0; RES_FIFO_FULL = 1'b0;
    head = 0; n_src = 0;
    drive_head();
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic single_entry(input string tag, input logic [127:0] ent,
                              input logic [4:0] sh, input logic [63:0] exp);
    clear_logs();
    head = 0; n_src = 1; src_mem[0] = ent;
    QUANT_SHIFT = sh;
    drive_head();
    run_until(tag, 1, 20);
    if (wr_q.size() >= 1 && pop_cyc_q.size() >= 1) begin
      check_eq({tag, "_data"}, wr_q[0], exp);
      check_eq({tag, "_latency"}, 64'(wr_cyc_q[0] - pop_cyc_q[0]), 64'd2);
    end else begin
      check_eq({tag, "_no_write"}, 64'(wr_q.size()), 64'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] exp_v;
    logic [11:0] mask_v;

    // Reset state
    #2;
    check_eq("rst_rena",  64'(EAQ_FIFO_RENA), 64'd0);
    check_eq("rst_wena",  64'(RES_FIFO_WENA), 64'd0);
    check_eq("rst_data",  RES_FIFO_DATA, 64'd0);
    check_eq("rst_tdone", 64'(TILE_DONE), 64'd0);
    check_eq("rst_tcnt",  64'(TILE_COUNT), 64'd0);
    check_eq("rst_busy0", 64'(BUSY), 64'd0);
    EAQ_FIFO_EMPTY = 1'b0;
    #1;
    check_eq("rst_busy1", 64'(BUSY), 64'd1);
    check_eq("rst_rena_ne", 64'(EAQ_FIFO_RENA), 64'd0);
    do_reset();

    // Basic shift by 8
    single_entry("basic", pack4(32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000),
                 5'd8, {16'h0100, 16'h0100, 16'h0100, 16'h0100});
    check_eq("hold_data", RES_FIFO_DATA, {16'h0100, 16'h0100, 16'h0100, 16'h0100});
    check_eq("hold_wena", 64'(RES_FIFO_WENA), 64'd0);

    // Rounding
    single_entry("round", pack4(32'h00000180, 32'hFFFFFE80, 32'h0000007F, 32'h00000080),
                 5'd8, {16'h0001, 16'h0000, neg_out(16'hFFFF), 16'h0002});
    // Saturation with shift 0
    single_entry("sat0", pack4(32'h7FFFFFFF, 32'h80000000, 32'h00008000, 32'hFFFF7FFF),
                 5'd0, {neg_out(16'h8000), 16'h7FFF, neg_out(16'h8000), 16'h7FFF});
    // Rounding carry absorbed; other shift-1 cases
    single_entry("sat1", pack4(32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000003, 32'hFFFFFFFD),
                 5'd1, {neg_out(16'hFFFF), 16'h0002, 16'h0000, 16'h7FFF});
    // Small negatives with shift 0 (ReLU sensitive)
    single_entry("relu", pack4(32'hFFFFFF00, 32'h00000010, 32'h00000000, 32'hFFFFFFFF),
                 5'd0, {neg_out(16'hFFFF), 16'h0000, 16'h0010, neg_out(16'hFF00)});

    // Backpressure: 8 entries, FULL high in cycles 3..7
    do_reset();
    for (int i = 0; i < 8; i++)
      src_mem[i] = pack4(32'((i*4+0) << 8), 32'((i*4+1) << 8), 32'((i*4+2) << 8), 32'((i*4+3) << 8));
    n_src = 8; QUANT_SHIFT = 5'd8; full_lo = 3; full_hi = 7;
    drive_head();
    run_until("bp", 8, 60);
    for (int i = 0; i < 8 && i < wr_q.size(); i++) begin
      exp_v = {16'(i*4+3), 16'(i*4+2), 16'(i*4+1), 16'(i*4+0)};
      check_eq($sformatf("bp_data%0d", i), wr_q[i], exp_v);
    end
    check_eq("bp_rena_full", 64'(bp_rena), 64'd0);
    check_eq("bp_wena_full", 64'(full_wena), 64'd0);
    if (wr_cyc_q.size() == 8) begin
      check_eq("bp_first_wr", 64'(wr_cyc_q[0]), 64'd8);
      check_eq("bp_last_wr",  64'(wr_cyc_q[7]), 64'd15);
    end

    // Halt in cycles 2..3 with two entries
    do_reset();
    src_mem[0] = pack4(32'd5, 32'd6, 32'd7, 32'd8);
    src_mem[1] = pack4(32'd9, 32'd10, 32'd11, 32'd12);
    n_src = 2; QUANT_SHIFT = 5'd0; halt_lo = 2; halt_hi = 3;
    drive_head();
    run_until("halt", 2, 30);
    check_eq("halt_enables", 64'(halt_err), 64'd0);
    if (wr_q.size() == 2 && pop_cyc_q.size() == 2) begin
      check_eq("halt_d0", wr_q[0], {16'd8, 16'd7, 16'd6, 16'd5});
      check_eq("halt_d1", wr_q[1], {16'd12, 16'd11, 16'd10, 16'd9});
      check_eq("halt_pop1", 64'(pop_cyc_q[1]), 64'd4);
      check_eq("halt_wr0", 64'(wr_cyc_q[0]), 64'd5);
    end

    // Tiles: 9 entries then 3 more
    do_reset();
    for (int i = 0; i < 12; i++)
      src_mem[i] = pack4(32'(i*4+0), 32'(i*4+1), 32'(i*4+2), 32'(i*4+3));
    n_src = 9; QUANT_SHIFT = 5'd0;
    drive_head();
    run_until("tile9", 9, 40);
    mask_v = '0;
    for (int i = 0; i < 9 && i < td_q.size(); i++) mask_v[i] = td_q[i];
    check_eq("tile9_done_mask", 64'(mask_v), 64'h088);
    check_eq("tile9_count", 64'(TILE_COUNT), 64'd2);
    for (int i = 0; i < 9 && i < wr_q.size(); i++)
      check_eq($sformatf("tile_data%0d", i), wr_q[i],
               {16'(i*4+3), 16'(i*4+2), 16'(i*4+1), 16'(i*4+0)});
    n_src = 12;
    drive_head();
    run_until("tile12", 12, 40);
    mask_v = '0;
    for (int i = 0; i < 12 && i < td_q.size(); i++) mask_v[i] = td_q[i];
    check_eq("tile12_done_mask", 64'(mask_v), 64'h888);
    check_eq("tile12_count", 64'(TILE_COUNT), 64'd3);

    // Reset with two entries in flight
    do_reset();
    src_mem[0] = pack4(32'd1, 32'd2, 32'd3, 32'd4);
    src_mem[1] = pack4(32'd5, 32'd6, 32'd7, 32'd8);
    src_mem[2] = pack4(32'h00000300, 32'h00000100, 32'h7FFFFFFF, 32'h00000000);
    n_src = 2; QUANT_SHIFT = 5'd0;
    drive_head();
    tick();
    tick();
    rst = 1'b1;
    #1;
    check_eq("midrst_wena", 64'(RES_FIFO_WENA), 64'd0);
    check_eq("midrst_data", RES_FIFO_DATA, 64'd0);
    check_eq("midrst_rena", 64'(EAQ_FIFO_RENA), 64'd0);
    check_eq("midrst_busy", 64'(BUSY), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_logs();
    n_src = 3; QUANT_SHIFT = 5'd8;
    drive_head();
    run_until("postrst", 1, 20);
    check_eq("postrst_tcnt", 64'(TILE_COUNT), 64'd0);
    if (wr_q.size() == 1 && pop_cyc_q.size() == 1) begin
      check_eq("postrst_data", wr_q[0], {16'h0000, 16'h7FFF, 16'h0001, 16'h0003});
      check_eq("postrst_latency", 64'(wr_cyc_q[0] - pop_cyc_q[0]), 64'd2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
